// File: rtl/rca_nibble_seq.sv
// Multi-cycle WIDTH-bit adder built around a single 4-bit ripple-carry adder, one nibble per cycle, LSB first.
// Optional signed-overflow output ovf is enabled by defining RCA_SEQ_OVERFLOW_FLAG_EN.

module rca_4bit (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out
);

   logic carry;

   // Bit-serial ripple through the four full adders
   always_comb begin
      carry = c_in;
      s     = '0;
      for (int i = 0; i < 4; i++) begin
         s[i]  = x[i] ^ y[i] ^ carry;
         carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
      end
      c_out = carry;
   end

endmodule

module rca_nibble_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             busy
`ifdef RCA_SEQ_OVERFLOW_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]  aReg_q, aReg_d;
   logic [WIDTH-1:0]  bReg_q, bReg_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cOut_q, cOut_d;
`ifdef RCA_SEQ_OVERFLOW_FLAG_EN
   logic              ovf_q, ovf_d;
`endif

   logic [3:0] rcaX, rcaY, rcaS;
   logic       rcaCout;

   rca_4bit uRca (
      .x     (rcaX),
      .y     (rcaY),
      .c_in  (carry_q),
      .s     (rcaS),
      .c_out (rcaCout)
   );

   // Nibble select by idx, written as a compare loop to keep index widths exact
   always_comb begin
      rcaX = '0;
      rcaY = '0;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx_q == IDXW'(n)) begin
            rcaX = aReg_q[4*n +: 4];
            rcaY = bReg_q[4*n +: 4];
         end
      end
   end

   // Next-state and datapath updates; everything holds unless the state says otherwise
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      aReg_d  = aReg_q;
      bReg_d  = bReg_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cOut_d  = cOut_q;
`ifdef RCA_SEQ_OVERFLOW_FLAG_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               aReg_d  = a;
               bReg_d  = b;
               carry_d = c_in;
               idx_d   = '0;
               sum_d   = '0;
`ifdef RCA_SEQ_OVERFLOW_FLAG_EN
               ovf_d   = 1'b0;
`endif
               state_d = ADD;
            end
         end
         ADD: begin
            for (int n = 0; n < NIBBLES; n++) begin
               if (idx_q == IDXW'(n)) begin
                  sum_d[4*n +: 4] = rcaS;
               end
            end
            carry_d = rcaCout;
            if (idx_q == LAST_IDX) begin
               cOut_d  = rcaCout;
`ifdef RCA_SEQ_OVERFLOW_FLAG_EN
               ovf_d   = (aReg_q[WIDTH-1] == bReg_q[WIDTH-1]) && (rcaS[3] != aReg_q[WIDTH-1]);
`endif
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         aReg_q  <= '0;
         bReg_q  <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cOut_q  <= 1'b0;
`ifdef RCA_SEQ_OVERFLOW_FLAG_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         aReg_q  <= aReg_d;
         bReg_q  <= bReg_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cOut_q  <= cOut_d;
`ifdef RCA_SEQ_OVERFLOW_FLAG_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == ADD) || (state_q == DONE);
   assign sum       = sum_q;
   assign c_out     = cOut_q;
`ifdef RCA_SEQ_OVERFLOW_FLAG_EN
   assign ovf       = ovf_q;
`endif

endmodule
